risc_prog_loader: RTL
=====================

# risc_prog_loader

Program loader and run supervisor that sits directly upstream of `risc_cpu`. It accepts a program image as a byte stream and writes it into the CPU's 32×8 memory through a write port. It holds the CPU in reset during loading, releases it, counts run cycles until `halt` or a timeout, and reports the halt PC against an expected value. It replaces hand-preloaded memory images in system-level runs and gives benches a single pass/fail/timeout status.

## Interface
- `ADDR_W`, 5: CPU memory address width. Image depth is 2^ADDR_W.
- `DATA_W`, 8: memory word width.
- `TIMEOUT`, 2000: maximum run cycles before abort. Must be ≥2 and < 2^16.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- `s_valid`  in  1  image byte valid.
- `s_ready`  out  1  loader can accept a byte.
- `s_data`  in  DATA_W  image byte.
- `s_last`  in  1  final byte of the image.
- `mem_we`  out  1  CPU memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `cpu_rst`  out  1  active-high reset to `risc_cpu`.
- `cpu_halt`  in  1  CPU halt flag.
- `cpu_pc`  in  ADDR_W  CPU PC.
- `exp_pc`  in  ADDR_W  expected halt PC, sampled on `start`.
- `busy`  out  1  loader is in LOAD or RUN.
- `done`  out  1  run finished, either halted or timed out.
- `pass`  out  1  halted and `cpu_pc == exp_pc`.
- `timeout`  out  1  TIMEOUT reached without a halt.
- `run_cycles`  out  16  cycles spent in RUN.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE → LOAD on `start`. On entry: latch `exp_pc`; clear the address counter, `run_cycles`, `pass`, `timeout` and `done`.
- LOAD:
  - `s_ready` = 1.
  - Each `s_valid && s_ready` handshake writes `s_data` to the current address, then increments the address.
  - The handshake with `s_last`, or the handshake at address 2^ADDR_W−1, ends LOAD → RUN. If the image is full and `s_last` has not been seen, the remaining bytes are never accepted (`s_ready` = 0 outside LOAD).
  - Addresses that are not written keep their previous memory contents.
- RUN:
  - `cpu_rst` = 0.
  - `run_cycles` increments every RUN cycle.
  - `cpu_halt` = 1 → DONE, with `pass` = (`cpu_pc == exp_pc` latched).
  - `run_cycles == TIMEOUT−1` with no halt → DONE, with `timeout` = 1. If halt and timeout occur in the same cycle, halt wins.
- DONE:
  - `done` = 1 and `cpu_rst` = 1 (CPU frozen).
  - Status holds until `start`, which re-enters LOAD with a fresh status.
- `start` in LOAD or RUN is ignored.
- `cpu_halt` outside RUN is ignored.

## Timing
- Reset values: state IDLE, `cpu_rst` = 1, `s_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `busy` = 0, `done` = 0, `pass` = 0, `timeout` = 0, `run_cycles` = 0.
- All outputs are registered, except `s_ready`, which is decoded from state.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` assert in the cycle after the handshake, for exactly one cycle.
- Back-to-back handshakes give one write per cycle.
- After the final handshake, the last write occurs in the first RUN cycle, with `cpu_rst` still 1. `cpu_rst` falls on the second RUN cycle, so the CPU never sees a partially written image. `run_cycles` counts from that second cycle.
- `done` and the status bits assert in the cycle after halt or timeout is detected.
- Asynchronous reset mid-LOAD or mid-RUN returns immediately to IDLE with `cpu_rst` = 1. A partially written image is left in memory.

## Structure
- Shared package `risc_pkg`:
  - `ADDR_W` and `DATA_W` defaults.
  - Loader state enum `ldr_state_t`.
  - Status bit positions.
- Add a `HLT` opcode constant to `risc_pkg` if it is not already present.
- Optional sub-module `risc_run_timer`: saturating 16-bit cycle counter with timeout compare.
- Top-level `risc_system` instantiates `risc_prog_loader` and `risc_cpu`, sharing `clk`. Inside it, `risc_cpu.rst` is driven by `cpu_rst`.

## Test plan
- 13-byte Fibonacci image, `s_last` on byte 13, `exp_pc` = 0x0C, streamed with no gaps → 13 writes to 0x00–0x0C on consecutive cycles, `cpu_rst` falls, halt at 0x0C → `done` = 1, `pass` = 1, `timeout` = 0.
- Same image with `exp_pc` = 0x0B → `done` = 1, `pass` = 0.
- Image with no HLT instruction, `TIMEOUT` = 50 → `done` = 1, `timeout` = 1, `run_cycles` = 49, `cpu_rst` = 1.
- 40-byte stream with no `s_last` → exactly 32 writes (0x00–0x1F); `s_ready` = 0 from the 33rd byte onward; RUN is entered.
- `s_valid` toggled randomly mid-load, plus `start` pulsed during RUN → writes only on handshakes with contiguous addresses; `start` is ignored.
- Reset pulled low mid-LOAD after 5 bytes → next edge shows IDLE, `cpu_rst` = 1, all status bits 0. A new `start` reloads from 0x00.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC CPU subsystem: default widths, the loader
// state encoding, status bit positions and the halt opcode.
package risc_pkg;

    localparam int RISC_ADDR_W = 5;
    localparam int RISC_DATA_W = 8;

    localparam logic [2:0] OP_HLT = 3'b000;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_RUN  = 2'd2,
        LDR_DONE = 2'd3
    } ldr_state_t;

    localparam int STAT_DONE    = 0;
    localparam int STAT_PASS    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_BUSY    = 3;

endpackage

// File: rtl/risc_run_timer.sv
// Saturating 16-bit run-cycle counter with a terminal-count flag at TIMEOUT-1.
module risc_run_timer #(
    parameter int TIMEOUT = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [15:0] o_count,
    output logic        o_tc
);

    localparam logic [15:0] TC_VALUE = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 16'd0;
        end else if (i_clr) begin
            r_count <= 16'd0;
        end else if (i_en && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TC_VALUE);

endmodule

// File: rtl/risc_prog_loader.sv
// Streams a program image into the CPU memory while holding the CPU in reset,
// then supervises the run until halt or timeout and reports pass/fail status.
//
// state | meaning
// IDLE  | waiting for start, CPU held in reset
// LOAD  | accepting image bytes, one memory write per handshake
// RUN   | first cycle drains the last write, then CPU released and timed
// DONE  | status held, CPU frozen in reset until the next start
module risc_prog_loader
    import risc_pkg::*;
#(
    parameter int ADDR_W  = RISC_ADDR_W,
    parameter int DATA_W  = RISC_DATA_W,
    parameter int TIMEOUT = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic [ADDR_W-1:0] exp_pc,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       run_cycles
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    ldr_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_exp_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;

    logic              w_hs;
    logic              w_start_ok;
    logic              w_run_active;
    logic              w_tmr_en;
    logic              w_tc;
    logic [15:0]       w_run_cycles;

    assign s_ready      = (r_state == LDR_LOAD);
    assign w_hs         = s_valid && s_ready;
    assign w_start_ok   = start && ((r_state == LDR_IDLE) || (r_state == LDR_DONE));
    // The CPU only runs once cpu_rst has dropped, i.e. from the second RUN cycle.
    assign w_run_active = (r_state == LDR_RUN) && !r_cpu_rst;
    assign w_tmr_en     = w_run_active && !cpu_halt && !w_tc;

    risc_run_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_run_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start_ok),
        .i_en    (w_tmr_en),
        .o_count (w_run_cycles),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= LDR_IDLE;
            r_addr      <= '0;
            r_exp_pc    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_cpu_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                LDR_IDLE, LDR_DONE: begin
                    if (start) begin
                        r_state   <= LDR_LOAD;
                        r_exp_pc  <= exp_pc;
                        r_addr    <= '0;
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                LDR_LOAD: begin
                    if (w_hs) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= s_data;
                        r_addr      <= r_addr + 1'b1;
                        if (s_last || (r_addr == ADDR_LAST)) begin
                            r_state <= LDR_RUN;
                        end
                    end
                end
                LDR_RUN: begin
                    if (r_cpu_rst) begin
                        r_cpu_rst <= 1'b0;
                    end else if (cpu_halt) begin
                        r_state   <= LDR_DONE;
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= (cpu_pc == r_exp_pc);
                    end else if (w_tc) begin
                        r_state   <= LDR_DONE;
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= LDR_IDLE;
            endcase
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign timeout    = r_timeout;
    assign run_cycles = w_run_cycles;

endmodule
